keyword_tokenizer: RTL

Upstream lexing stage for the begin/end nesting checker. It accepts a raw byte stream under a valid/ready handshake, splits the stream into words at delimiter bytes, and classifies each word as BEGIN, END or OTHER. Classified tokens are buffered in a small FIFO, and the nesting checker consumes them one token per handshake.

---
 rtl/tokenizer_pkg.sv | 53 +++++
 rtl/token_fifo.sv | 61 ++++++
 rtl/keyword_tokenizer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tokenizer_pkg.sv
// Shared encodings for the keyword tokenizer: token kinds, FSM states,
// delimiter bytes and the "begin"/"end" keyword constants.
package tokenizer_pkg;

  typedef enum logic [1:0] {
    TOK_NONE  = 2'd0,
    TOK_BEGIN = 2'd1,
    TOK_END   = 2'd2,
    TOK_OTHER = 2'd3
  } tok_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MATCH = 2'd1,
    ST_OTHER = 2'd2
  } tok_state_e;

  localparam logic [7:0] DELIM_SP  = 8'h20;
  localparam logic [7:0] DELIM_TAB = 8'h09;
  localparam logic [7:0] DELIM_LF  = 8'h0A;
  localparam logic [7:0] DELIM_CR  = 8'h0D;

  localparam logic [39:0] KW_BEGIN     = "begin";
  localparam logic [23:0] KW_END       = "end";
  localparam logic [2:0]  KW_BEGIN_LEN = 3'd5;
  localparam logic [2:0]  KW_END_LEN   = 3'd3;

  function automatic logic is_delim(input logic [7:0] c);
    return (c == DELIM_SP) || (c == DELIM_TAB) || (c == DELIM_LF) || (c == DELIM_CR);
  endfunction

  // Expected character at position p; positions past the keyword never match.
  function automatic logic [7:0] kw_begin_char(input logic [2:0] p);
    case (p)
      3'd0:    return KW_BEGIN[39:32];
      3'd1:    return KW_BEGIN[31:24];
      3'd2:    return KW_BEGIN[23:16];
      3'd3:    return KW_BEGIN[15:8];
      3'd4:    return KW_BEGIN[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] kw_end_char(input logic [2:0] p);
    case (p)
      3'd0:    return KW_END[23:16];
      3'd1:    return KW_END[15:8];
      3'd2:    return KW_END[7:0];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/token_fifo.sv
// Token FIFO: power-of-two depth, async reset, full/empty flags and a
// registered head word so the consumer sees a flop-driven token.
module token_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [AW-1:0] IDX_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [W-1:0] r_head;
  logic [AW:0]  w_count;
  logic         w_push;
  logic         w_pop;
  logic [AW-1:0] w_rd_next;

  assign w_count   = r_wr - r_rd;
  assign o_full    = (w_count == FULL_CNT);
  assign o_empty   = (w_count == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign w_rd_next = r_rd[AW-1:0] + IDX_ONE;
  assign o_head    = r_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= i_din;
        r_wr <= r_wr + PTR_ONE;
      end
      if (w_pop) r_rd <= r_rd + PTR_ONE;
      // Head tracks the entry that will be at the read pointer after this edge.
      if (w_pop) begin
        if (w_count == PTR_ONE) r_head <= w_push ? i_din : '0;
        else                    r_head <= r_mem[w_rd_next];
      end else if (w_push && o_empty) begin
        r_head <= i_din;
      end
    end
  end

endmodule

// File: rtl/keyword_tokenizer.sv
// Splits a byte stream into words and classifies each as BEGIN/END/OTHER.
// Define TOKENIZER_CASE_FOLD_EN to fold 'A'-'Z' before keyword comparison.
module keyword_tokenizer
  import tokenizer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             tok_valid,
  output logic [1:0]       tok_kind,
  output logic [LEN_W-1:0] tok_len,
  input  logic             tok_ready,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  tok_state_e       r_state, w_state_a, w_state_n;
  logic [2:0]       r_pos, w_pos_a, w_pos_n;
  logic             r_b_ok, w_b_a, w_b_n;
  logic             r_e_ok, w_e_a, w_e_n;
  logic [LEN_W-1:0] r_len, w_len_a, w_len_n;

  logic             w_fifo_full, w_fifo_empty;
  logic             w_byte_acc, w_flush_acc;
  logic [7:0]       w_c;
  logic             w_push;
  tok_kind_e        w_push_kind;
  logic [LEN_W-1:0] w_push_len;
  logic [LEN_W+1:0] w_head;
  logic             w_pop;

  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef TOKENIZER_CASE_FOLD_EN
    if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
    return c;
`else
    return c;
`endif
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] l);
    return (l == LEN_MAX) ? l : l + LEN_ONE;
  endfunction

  function automatic tok_kind_e classify(input logic b, input logic e, input logic [2:0] p);
    if (b && p == KW_BEGIN_LEN) return TOK_BEGIN;
    if (e && p == KW_END_LEN)   return TOK_END;
    return TOK_OTHER;
  endfunction

  assign in_ready    = !w_fifo_full;
  assign w_byte_acc  = in_valid && in_ready;
  assign w_flush_acc = flush && in_ready;
  assign w_c         = fold(in_data);
  assign busy        = (r_state != ST_IDLE);

  // First the accepted byte advances the word, then flush terminates it.
  always_comb begin
    w_state_a   = r_state;
    w_pos_a     = r_pos;
    w_b_a       = r_b_ok;
    w_e_a       = r_e_ok;
    w_len_a     = r_len;
    w_push      = 1'b0;
    w_push_kind = TOK_NONE;
    w_push_len  = r_len;
    if (w_byte_acc) begin
      if (is_delim(in_data)) begin
        if (r_state != ST_IDLE) begin
          w_push      = 1'b1;
          w_push_kind = classify(r_b_ok, r_e_ok, r_pos);
          w_push_len  = r_len;
          w_state_a   = ST_IDLE;
          w_pos_a     = '0;
          w_b_a       = 1'b0;
          w_e_a       = 1'b0;
          w_len_a     = '0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            w_pos_a   = 3'd1;
            w_len_a   = LEN_ONE;
            w_b_a     = (w_c == kw_begin_char(3'd0));
            w_e_a     = (w_c == kw_end_char(3'd0));
            w_state_a = (w_b_a || w_e_a) ? ST_MATCH : ST_OTHER;
          end
          ST_MATCH: begin
            w_b_a     = r_b_ok && (r_pos < KW_BEGIN_LEN) && (w_c == kw_begin_char(r_pos));
            w_e_a     = r_e_ok && (r_pos < KW_END_LEN) && (w_c == kw_end_char(r_pos));
            w_pos_a   = r_pos + 3'd1;
            w_len_a   = sat_inc(r_len);
            w_state_a = (w_b_a || w_e_a) ? ST_MATCH : ST_OTHER;
          end
          default: w_len_a = sat_inc(r_len);
        endcase
      end
    end

    w_state_n = w_state_a;
    w_pos_n   = w_pos_a;
    w_b_n     = w_b_a;
    w_e_n     = w_e_a;
    w_len_n   = w_len_a;
    if (w_flush_acc && w_state_a != ST_IDLE) begin
      w_push      = 1'b1;
      w_push_kind = classify(w_b_a, w_e_a, w_pos_a);
      w_push_len  = w_len_a;
      w_state_n   = ST_IDLE;
      w_pos_n     = '0;
      w_b_n       = 1'b0;
      w_e_n       = 1'b0;
      w_len_n     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pos   <= '0;
      r_b_ok  <= 1'b0;
      r_e_ok  <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_n;
      r_pos   <= w_pos_n;
      r_b_ok  <= w_b_n;
      r_e_ok  <= w_e_n;
      r_len   <= w_len_n;
    end
  end

  assign tok_valid = !w_fifo_empty;
  assign w_pop     = tok_valid && tok_ready;

  token_fifo #(
    .DEPTH (DEPTH),
    .W     (LEN_W + 2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   ({2'(w_push_kind), w_push_len}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign tok_kind = w_head[LEN_W+1:LEN_W];
  assign tok_len  = w_head[LEN_W-1:0];

endmodule
